// File: rtl/dma_io_responder.sv
// Single-channel DMA I/O responder: a byte FIFO between device logic and a DMA
// controller, with a REQ/WAIT/XFER handshake, programmable wait states and EOP handling.
module dma_io_responder #(
  parameter int DEPTH = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic       DIR,
  input  logic [1:0] WS,
  output logic       DREQ,
  input  logic       DACK,
  input  logic       IOR,
  input  logic       IOW,
  output logic       RDY,
  input  logic       EOP,
  input  logic [7:0] IO_Data_in,
  output logic [7:0] IO_Data_out,
  input  logic       Dev_wr,
  input  logic [7:0] Dev_wdata,
  input  logic       Dev_rd,
  output logic [7:0] Dev_rdata,
  output logic [3:0] Count,
  output logic       DONE,
  output logic       OVF,
  output logic       UNF,
  input  logic       DONE_CLR
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_XFER = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic          dir_r;
  logic [1:0]    ws_r;
  logic [1:0]    cnt_r;
  logic [1:0]    cnt_nxt_s;
  logic [AW-1:0] wptr_r;
  logic [AW-1:0] rptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt_s;
  logic [7:0]    mem_r [DEPTH];
  logic          ovf_r;
  logic          unf_r;
  logic          dreq_r;
  logic          rdy_r;
  logic          done_r;

  logic          dir_eff_s;
  logic          strobe_s;
  logic          xfer_s;
  logic          full_s;
  logic          empty_s;
  logic          push_req_s;
  logic          pop_req_s;
  logic          push_ok_s;
  logic          pop_ok_s;
  logic [7:0]    push_data_s;
  logic [7:0]    head_s;

  // DIR=0 needs a byte to hand out; DIR=1 needs room to accept one.
  function automatic logic ready_cond(input logic dir, input logic [CW-1:0] cnt);
    if (dir) begin
      ready_cond = (cnt < CW'(DEPTH));
    end else begin
      ready_cond = (cnt != {CW{1'b0}});
    end
  endfunction

  // DIR/WS are live only while idle; elsewhere the latched copies govern.
  assign dir_eff_s   = (state_r == ST_IDLE) ? DIR : dir_r;
  assign strobe_s    = DACK & (dir_r ? IOW : IOR);
  assign xfer_s      = (state_r == ST_XFER);
  assign full_s      = (count_r == CW'(DEPTH));
  assign empty_s     = (count_r == {CW{1'b0}});
  assign push_req_s  = dir_eff_s ? xfer_s : Dev_wr;
  assign pop_req_s   = dir_eff_s ? Dev_rd : xfer_s;
  assign push_ok_s   = push_req_s & ~full_s;
  assign pop_ok_s    = pop_req_s & ~empty_s;
  assign push_data_s = dir_eff_s ? IO_Data_in : Dev_wdata;
  assign head_s      = mem_r[rptr_r];

  // Occupancy after this edge's push/pop; used by the post-transfer decision.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_nxt_s = count_r + CW'(1'b1);
      2'b01:   count_nxt_s = count_r - CW'(1'b1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Handshake next-state and wait-counter logic.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (EN && ready_cond(DIR, count_r)) begin
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (!EN) begin
          state_nxt_s = ST_IDLE;
        end else if (EOP) begin
          state_nxt_s = ST_DONE;
        end else if (strobe_s) begin
          cnt_nxt_s   = ws_r;
          state_nxt_s = (ws_r == 2'd0) ? ST_XFER : ST_WAIT;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (!EN) begin
          state_nxt_s = ST_IDLE;
        end else if (EOP) begin
          state_nxt_s = ST_DONE;
        end else if (!strobe_s) begin
          state_nxt_s = ST_REQ;
        end else if (cnt_r == 2'd1) begin
          cnt_nxt_s   = 2'd0;
          state_nxt_s = ST_XFER;
        end else begin
          cnt_nxt_s   = cnt_r - 2'd1;
          state_nxt_s = ST_WAIT;
        end
      end
      ST_XFER: begin
        if (EOP) begin
          state_nxt_s = ST_DONE;
        end else if (EN && ready_cond(dir_r, count_nxt_s)) begin
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DONE: begin
        if (DONE_CLR || !EN) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 2'd0;
      end
    endcase
  end

  // Control state, latched configuration and registered handshake outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= ST_IDLE;
      cnt_r   <= 2'd0;
      dir_r   <= 1'b0;
      ws_r    <= 2'd0;
      dreq_r  <= 1'b0;
      rdy_r   <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (state_r == ST_IDLE) begin
        dir_r <= DIR;
        ws_r  <= WS;
      end
      dreq_r <= (state_nxt_s == ST_REQ) || (state_nxt_s == ST_WAIT);
      rdy_r  <= (state_nxt_s == ST_XFER);
      done_r <= (state_nxt_s == ST_DONE);
    end
  end

  // FIFO pointers, occupancy and sticky error flags.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr_r  <= {AW{1'b0}};
      rptr_r  <= {AW{1'b0}};
      count_r <= {CW{1'b0}};
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wptr_r <= wptr_r + AW'(1'b1);
      end
      if (pop_ok_s) begin
        rptr_r <= rptr_r + AW'(1'b1);
      end
      count_r <= count_nxt_s;
      if (!dir_eff_s && Dev_wr && full_s) begin
        ovf_r <= 1'b1;
      end
      if (dir_eff_s && Dev_rd && empty_s) begin
        unf_r <= 1'b1;
      end
    end
  end

  // FIFO storage; contents are meaningless once the pointers are reset.
  always_ff @(posedge CLK) begin
    if (push_ok_s) begin
      mem_r[wptr_r] <= push_data_s;
    end
  end

  assign DREQ        = dreq_r;
  assign RDY         = rdy_r;
  assign DONE        = done_r;
  assign OVF         = ovf_r;
  assign UNF         = unf_r;
  assign Count       = 4'(count_r);
  assign Dev_rdata   = head_s;
  assign IO_Data_out = (!dir_eff_s && DACK && IOR) ? head_s : 8'h00;

endmodule

// File: tb/tb_dma_io_responder.sv
// Directed self-checking bench for dma_io_responder; inputs change and outputs
// are sampled on the falling clock edge.
module tb_dma_io_responder;

  logic       CLK;
  logic       RST;
  logic       EN;
  logic       DIR;
  logic [1:0] WS;
  logic       DREQ;
  logic       DACK;
  logic       IOR;
  logic       IOW;
  logic       RDY;
  logic       EOP;
  logic [7:0] IO_Data_in;
  logic [7:0] IO_Data_out;
  logic       Dev_wr;
  logic [7:0] Dev_wdata;
  logic       Dev_rd;
  logic [7:0] Dev_rdata;
  logic [3:0] Count;
  logic       DONE;
  logic       OVF;
  logic       UNF;
  logic       DONE_CLR;

  int checks = 0;
  int errors = 0;

  dma_io_responder #(.DEPTH(8)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .DIR(DIR), .WS(WS), .DREQ(DREQ),
    .DACK(DACK), .IOR(IOR), .IOW(IOW), .RDY(RDY), .EOP(EOP),
    .IO_Data_in(IO_Data_in), .IO_Data_out(IO_Data_out),
    .Dev_wr(Dev_wr), .Dev_wdata(Dev_wdata), .Dev_rd(Dev_rd),
    .Dev_rdata(Dev_rdata), .Count(Count), .DONE(DONE), .OVF(OVF),
    .UNF(UNF), .DONE_CLR(DONE_CLR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic dev_push(input logic [7:0] d);
    Dev_wr    = 1'b1;
    Dev_wdata = d;
    @(negedge CLK);
    Dev_wr    = 1'b0;
  endtask

  logic [7:0] seq_bytes [3];

  initial begin
    seq_bytes[0] = 8'h05;
    seq_bytes[1] = 8'h0A;
    seq_bytes[2] = 8'h0F;
    RST = 1'b1; EN = 1'b0; DIR = 1'b0; WS = 2'd0; DACK = 1'b0; IOR = 1'b0;
    IOW = 1'b0; EOP = 1'b0; IO_Data_in = 8'h00; Dev_wr = 1'b0;
    Dev_wdata = 8'h00; Dev_rd = 1'b0; DONE_CLR = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    check("rst_dreq", 16'(DREQ), 16'd0);
    check("rst_rdy", 16'(RDY), 16'd0);
    check("rst_count", 16'(Count), 16'd0);
    check("rst_done", 16'(DONE), 16'd0);
    check("rst_ovf", 16'(OVF), 16'd0);
    check("rst_unf", 16'(UNF), 16'd0);
    check("rst_iodata", 16'(IO_Data_out), 16'h00);

    // Device-to-memory, no wait states, three bytes.
    for (int i = 0; i < 3; i++) dev_push(seq_bytes[i]);
    check("rd_count_pre", 16'(Count), 16'd3);
    check("rd_dreq_pre", 16'(DREQ), 16'd0);
    EN = 1'b1; DACK = 1'b1; IOR = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("rd_dreq", 16'(DREQ), 16'd1);
      check("rd_rdy_lo", 16'(RDY), 16'd0);
      check("rd_count", 16'(Count), 16'(3 - i));
      @(negedge CLK);
      check("rd_rdy_hi", 16'(RDY), 16'd1);
      check("rd_data", 16'(IO_Data_out), 16'(seq_bytes[i]));
    end
    @(negedge CLK);
    check("rd_end_dreq", 16'(DREQ), 16'd0);
    check("rd_end_rdy", 16'(RDY), 16'd0);
    check("rd_end_count", 16'(Count), 16'd0);
    EN = 1'b0; DACK = 1'b0; IOR = 1'b0;

    // Memory-to-device, two wait states.
    DIR = 1'b1; WS = 2'd2; IO_Data_in = 8'h50; EN = 1'b1;
    @(negedge CLK);
    check("wr_dreq", 16'(DREQ), 16'd1);
    DACK = 1'b1; IOW = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      check("wr_rdy_wait", 16'(RDY), 16'd0);
      check("wr_dreq_wait", 16'(DREQ), 16'd1);
    end
    @(negedge CLK);
    check("wr_rdy_hi", 16'(RDY), 16'd1);
    check("wr_count_pre", 16'(Count), 16'd0);
    EN = 1'b0; DACK = 1'b0; IOW = 1'b0;
    @(negedge CLK);
    check("wr_rdy_lo", 16'(RDY), 16'd0);
    check("wr_count", 16'(Count), 16'd1);
    check("wr_dev_rdata", 16'(Dev_rdata), 16'h50);
    check("wr_dreq_end", 16'(DREQ), 16'd0);
    Dev_rd = 1'b1;
    @(negedge CLK);
    check("pop_count", 16'(Count), 16'd0);
    check("pop_unf_clear", 16'(UNF), 16'd0);
    @(negedge CLK);
    check("pop_unf_set", 16'(UNF), 16'd1);
    check("pop_count_empty", 16'(Count), 16'd0);
    Dev_rd = 1'b0;

    // EOP during WAIT.
    WS = 2'd3; EN = 1'b1;
    @(negedge CLK);
    check("eop_dreq_req", 16'(DREQ), 16'd1);
    DACK = 1'b1; IOW = 1'b1;
    @(negedge CLK);
    check("eop_dreq_wait", 16'(DREQ), 16'd1);
    check("eop_rdy_wait", 16'(RDY), 16'd0);
    EOP = 1'b1;
    @(negedge CLK);
    check("eop_done", 16'(DONE), 16'd1);
    check("eop_rdy", 16'(RDY), 16'd0);
    check("eop_dreq", 16'(DREQ), 16'd0);
    check("eop_count", 16'(Count), 16'd0);
    EOP = 1'b0;
    @(negedge CLK);
    check("eop_done_hold", 16'(DONE), 16'd1);
    DONE_CLR = 1'b1; DACK = 1'b0; IOW = 1'b0;
    @(negedge CLK);
    check("eop_done_clr", 16'(DONE), 16'd0);
    check("eop_idle_dreq", 16'(DREQ), 16'd0);
    DONE_CLR = 1'b0; EN = 1'b0;

    // DACK dropped in WAIT, then a normal transfer with three wait states.
    IO_Data_in = 8'hA7; EN = 1'b1;
    @(negedge CLK);
    check("drop_dreq_req", 16'(DREQ), 16'd1);
    DACK = 1'b1; IOW = 1'b1;
    @(negedge CLK);
    check("drop_dreq_wait", 16'(DREQ), 16'd1);
    DACK = 1'b0;
    @(negedge CLK);
    check("drop_dreq_back", 16'(DREQ), 16'd1);
    check("drop_rdy", 16'(RDY), 16'd0);
    check("drop_count", 16'(Count), 16'd0);
    @(negedge CLK);
    check("drop_dreq_hold", 16'(DREQ), 16'd1);
    check("drop_rdy_hold", 16'(RDY), 16'd0);
    DACK = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check("drop_rdy_wait", 16'(RDY), 16'd0);
    end
    @(negedge CLK);
    check("drop_rdy_hi", 16'(RDY), 16'd1);
    EN = 1'b0; DACK = 1'b0; IOW = 1'b0;
    @(negedge CLK);
    check("drop_count_after", 16'(Count), 16'd1);
    check("drop_dev_rdata", 16'(Dev_rdata), 16'hA7);
    check("drop_rdy_lo", 16'(RDY), 16'd0);
    Dev_rd = 1'b1;
    @(negedge CLK);
    Dev_rd = 1'b0;
    check("drop_drain", 16'(Count), 16'd0);

    // Overflow: nine device pushes into an 8-deep FIFO, then drain.
    DIR = 1'b0; WS = 2'd0;
    for (int i = 0; i < 9; i++) dev_push(8'h11 + 8'(i));
    check("ovf_count", 16'(Count), 16'd8);
    check("ovf_flag", 16'(OVF), 16'd1);
    EN = 1'b1; DACK = 1'b1; IOR = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      check("ovf_dreq", 16'(DREQ), 16'd1);
      @(negedge CLK);
      check("ovf_rdy", 16'(RDY), 16'd1);
      check("ovf_data", 16'(IO_Data_out), 16'(8'h11 + 8'(i)));
    end
    @(negedge CLK);
    check("ovf_drained", 16'(Count), 16'd0);
    check("ovf_dreq_end", 16'(DREQ), 16'd0);
    EN = 1'b0; DACK = 1'b0; IOR = 1'b0;

    // Reset in the middle of WAIT with data in the FIFO.
    dev_push(8'h33);
    dev_push(8'h44);
    check("mid_count", 16'(Count), 16'd2);
    WS = 2'd3; EN = 1'b1; DACK = 1'b1; IOR = 1'b1;
    @(negedge CLK);
    check("mid_dreq_req", 16'(DREQ), 16'd1);
    @(negedge CLK);
    check("mid_dreq_wait", 16'(DREQ), 16'd1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0; EN = 1'b0; DACK = 1'b0; IOR = 1'b0;
    check("mid_rst_dreq", 16'(DREQ), 16'd0);
    check("mid_rst_rdy", 16'(RDY), 16'd0);
    check("mid_rst_count", 16'(Count), 16'd0);
    check("mid_rst_ovf", 16'(OVF), 16'd0);
    check("mid_rst_unf", 16'(UNF), 16'd0);
    check("mid_rst_done", 16'(DONE), 16'd0);
    @(negedge CLK);
    check("mid_idle_dreq", 16'(DREQ), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_io_responder.md
DMA_IO_RESPONDER -- requirements
Module: dma_io_responder

Interface
REQ-001 Parameter DEPTH, default 8, FIFO depth in bytes; fixed power of two.
REQ-002 CLK  in  1  sole clock; all state changes on rising edge.
REQ-003 RST  in  1  reset, synchronous and active-high.
REQ-004 EN  in  1  channel enable from device logic.
REQ-005 DIR  in  1  0 = device-to-memory (DMAC reads via IOR); 1 = memory-to-device (DMAC writes via IOW).
REQ-006 WS  in  2  wait states inserted before RDY (0-3).
REQ-007 DREQ  out  1  DMA request to controller.
REQ-008 DACK  in  1  DMA acknowledge from controller.
REQ-009 IOR / IOW  in  1 each  I/O read / write strobes from controller.
REQ-010 RDY  out  1  transfer-complete/ready to controller.
REQ-011 EOP  in  1  end-of-process from controller.
REQ-012 IO_Data_in  in  8  write data from controller (DIR=1).
REQ-013 IO_Data_out  out  8  read data to controller (DIR=0).
REQ-014 Dev_wr, Dev_wdata[7:0]  in  device-side push (DIR=0).
REQ-015 Dev_rd  in  1; Dev_rdata[7:0]  out  device-side pop (DIR=1); Dev_rdata = FIFO head.
REQ-016 Count  out  4  FIFO occupancy 0..DEPTH; DONE, OVF, UNF  out  1 each; DONE_CLR  in  1.

Function
REQ-017 FSM states IDLE, REQ, WAIT, XFER, DONE; DREQ=1 only in REQ and WAIT; RDY=1 only in XFER.
REQ-018 "Ready condition": DIR=0 -> Count>=1; DIR=1 -> Count<DEPTH.
REQ-019 IDLE -> REQ when EN=1 and ready condition true; else stay.
REQ-020 REQ: strobe = DACK & (DIR ? IOW : IOR); on strobe, load wait counter with WS; WS=0 -> XFER, else -> WAIT.
REQ-021 WAIT: counter decrements each cycle; at counter=1 -> XFER; strobe low in any WAIT cycle -> REQ, no transfer.
REQ-022 RDY rises exactly WS+1 cycles after the edge sampling the strobe; lasts exactly one cycle.
REQ-023 XFER edge: DIR=0 pops FIFO head; DIR=1 pushes IO_Data_in (sampled that cycle).
REQ-024 After XFER: EOP=1 -> DONE; else EN=1 and ready condition -> REQ; else -> IDLE.
REQ-025 IO_Data_out = FIFO head while DIR=0, DACK=1, IOR=1; else 8'h00.
REQ-026 EOP=1 in REQ or WAIT -> DONE next cycle; no transfer, Count unchanged.
REQ-027 DONE: DONE=1, DREQ=0; exit to IDLE on DONE_CLR=1 or EN=0.
REQ-028 EN=0 in REQ/WAIT -> IDLE next cycle, no transfer; EN=0 in XFER lets the transfer complete, then IDLE.
REQ-029 Device push when Count=DEPTH: data dropped, OVF set (sticky); device pop when Count=0: ignored, UNF set (sticky); both cleared only by RST.
REQ-030 Same-cycle device push and DMAC pop (or DMAC push and device pop): both performed, Count unchanged; legal at full/empty only for the side that is valid.
REQ-031 FIFO pointers wrap modulo DEPTH; Count is the exact difference, never exceeds DEPTH.
REQ-032 DIR and WS changes take effect only in IDLE; held values are latched on IDLE exit.

Reset
REQ-033 RST=1 at an edge: state IDLE, pointers 0, Count=0, DREQ=0, RDY=0, DONE=OVF=UNF=0, IO_Data_out=8'h00, wait counter 0.
REQ-034 RST overrides all inputs, including mid-transfer; FIFO contents discarded.

Verification
REQ-035 Reset: RST high 1 cycle mid-WAIT -> next cycle DREQ=0, RDY=0, Count=0, flags 0.
REQ-036 DIR=0, WS=0: push 05,0A,0F; EN=1; DACK+IOR held -> DREQ high 1 cycle after EN; IO_Data_out 05,0A,0F; one RDY pulse per byte; final Count=0, DREQ=0.
REQ-037 DIR=1, WS=2: IOW+DACK with IO_Data_in=0x50 -> RDY high exactly 3 cycles after strobe sample; Count 0->1; Dev_rdata=0x50.
REQ-038 EOP asserted during WAIT -> DONE=1 next cycle, no RDY, Count unchanged; DONE_CLR -> IDLE.
REQ-039 DIR=0: 9 pushes with DEPTH=8 -> Count=8, OVF=1, 9th byte absent from read-back.
REQ-040 DACK dropped during WAIT -> return to REQ, DREQ stays 1, no RDY, Count unchanged; reassert -> normal transfer.
